// File: rtl/csa_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined carry-save multiplier between two
// valid/ready requesters; a tag pipeline steers each product back to its owner.
module csa_mult_arbiter #(
    parameter int WIDTH = 26,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_out,
    output logic               rsp0_valid,
    output logic [2*WIDTH-1:0] rsp0_data,
    output logic               rsp1_valid,
    output logic [2*WIDTH-1:0] rsp1_data,
    output logic               busy
);

    // One stage covers the operand register, LAT more cover the multiplier.
    localparam int DEPTH = LAT + 1;

    logic             prio;
    logic             grant0;
    logic             grant1;
    logic             retire;
    logic [DEPTH-1:0] tag_vld_p;
    logic [DEPTH-1:0] tag_id_p;

    // prio names the requester that wins when both are valid.
    always_comb begin
        grant0 = rstn && req0_valid && (!req1_valid || !prio);
        grant1 = rstn && req1_valid && (!req0_valid ||  prio);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Issue stage: operands and ownership tag enter the pipeline together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio      <= 1'b0;
            tag_vld_p <= '0;
            tag_id_p  <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            if (grant0) begin
                mul_a <= req0_a;
                mul_b <= req0_b;
                prio  <= 1'b1;
            end else if (grant1) begin
                mul_a <= req1_a;
                mul_b <= req1_b;
                prio  <= 1'b0;
            end else begin
                mul_a <= '0;
                mul_b <= '0;
            end
            tag_vld_p <= {tag_vld_p[DEPTH-2:0], grant0 | grant1};
            tag_id_p  <= {tag_id_p[DEPTH-2:0], grant1};
        end
    end

    // Retire stage: the oldest tag selects which response carries mul_out.
    always_comb begin
        retire     = rstn && tag_vld_p[DEPTH-1];
        rsp0_valid = retire && !tag_id_p[DEPTH-1];
        rsp1_valid = retire &&  tag_id_p[DEPTH-1];
        rsp0_data  = rsp0_valid ? mul_out : '0;
        rsp1_data  = rsp1_valid ? mul_out : '0;
        busy       = rstn && (|tag_vld_p);
    end

endmodule

// File: tb/tb_csa_mult_arbiter.sv
// Directed and scoreboarded bench for csa_mult_arbiter, with a behavioural
// one-cycle multiplier standing in for multiplier_csa_26b.
module tb_csa_mult_arbiter;

    localparam int W = 26;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [W-1:0]    req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_out = '0;
    logic            rsp0_valid, rsp1_valid, busy;
    logic [2*W-1:0]  rsp0_data, rsp1_data;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [2*W-1:0] exp0[$], exp1[$];
    int             due0[$], due1[$];

    logic prev_rstn = 1'b0, prev_v0 = 1'b0, prev_r0 = 1'b0, prev_v1 = 1'b0, prev_r1 = 1'b0;

    csa_mult_arbiter #(.WIDTH(W), .LAT(1)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mul_out <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
        cyc     <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: data order per requester and exact two-cycle latency.
    always @(negedge clk) begin
        if (!rstn) begin
            exp0.delete(); exp1.delete(); due0.delete(); due1.delete();
        end else begin
            if (rsp0_valid) begin
                if (exp0.size() == 0 || due0.size() == 0) check("rsp0_unexpected", 1, 0);
                else begin
                    check("rsp0_data", rsp0_data, exp0.pop_front());
                    check("rsp0_cycle", cyc, due0.pop_front());
                end
            end else check("rsp0_idle_data", rsp0_data, 0);
            if (rsp1_valid) begin
                if (exp1.size() == 0 || due1.size() == 0) check("rsp1_unexpected", 1, 0);
                else begin
                    check("rsp1_data", rsp1_data, exp1.pop_front());
                    check("rsp1_cycle", cyc, due1.pop_front());
                end
            end else check("rsp1_idle_data", rsp1_data, 0);
            if (due0.size() > 0 && due0[0] < cyc) begin
                check("rsp0_missing", 0, 1);
                void'(due0.pop_front());
                if (exp0.size() > 0) void'(exp0.pop_front());
            end
            if (due1.size() > 0 && due1[0] < cyc) begin
                check("rsp1_missing", 0, 1);
                void'(due1.pop_front());
                if (exp1.size() > 0) void'(exp1.pop_front());
            end
            if (rsp0_valid && rsp1_valid) check("rsp_both", 1, 0);
            if (req0_ready && req1_ready) check("ready_both", 1, 0);
            if (req0_valid && req0_ready) due0.push_back(cyc + 2);
            if (req1_valid && req1_ready) due1.push_back(cyc + 2);
        end
    end

    // Requesters must hold valid until accepted.
    always @(posedge clk) begin
        if (rstn && prev_rstn && prev_v0 && !prev_r0) check("hold_valid0", req0_valid, 1);
        if (rstn && prev_rstn && prev_v1 && !prev_r1) check("hold_valid1", req1_valid, 1);
        prev_rstn = rstn;
        prev_v0 = req0_valid; prev_r0 = req0_ready;
        prev_v1 = req1_valid; prev_r1 = req1_ready;
    end

    task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] p);
        int budget = 20;
        if (n == 0) begin exp0.push_back(p); req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else        begin exp1.push_back(p); req1_a = a; req1_b = b; req1_valid = 1'b1; end
        #1;
        while (!(n == 0 ? req0_ready : req1_ready) && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (budget == 0) check("issue_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a requester pushing during reset
        tick();
        req0_valid = 1'b1;
        #1;
        check("reset_ready0", req0_ready, 0);
        check("reset_busy", busy, 0);
        tick();
        req0_valid = 1'b0;
        check("reset_mul_a", mul_a, 0);
        check("reset_mul_b", mul_b, 0);
        check("reset_rsp0_valid", rsp0_valid, 0);
        rstn = 1'b1;
        tick();
        check("idle_busy", busy, 0);
        check("idle_rsp1_valid", rsp1_valid, 0);

        // 1: single op 3*5
        exp0.push_back(52'd15);
        req0_a = 26'd3; req0_b = 26'd5; req0_valid = 1'b1;
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("t1_busy_t1", busy, 1);
        check("t1_mul_a", mul_a, 3);
        check("t1_mul_b", mul_b, 5);
        check("t1_rsp0_early", rsp0_valid, 0);
        tick();
        check("t1_rsp0_valid", rsp0_valid, 1);
        check("t1_rsp0_data", rsp0_data, 15);
        check("t1_rsp1_valid", rsp1_valid, 0);
        check("t1_busy_t2", busy, 1);
        tick();
        check("t1_busy_done", busy, 0);
        check("t1_rsp0_done", rsp0_valid, 0);
        check("t1_mul_a_idle", mul_a, 0);

        // 2: maximum operands, then zero times max
        issue(1, 26'h3FFFFFF, 26'h3FFFFFF, 52'hFFFFFF8000001);
        issue(1, 26'h0, 26'h3FFFFFF, 52'h0);
        repeat (4) tick();

        // 3: contention, grant order 0,1,0,1
        exp0.push_back(52'd2);  exp0.push_back(52'd12);
        exp1.push_back(52'd30); exp1.push_back(52'd56);
        req0_a = 26'd1; req0_b = 26'd2; req0_valid = 1'b1;
        req1_a = 26'd5; req1_b = 26'd6; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_grant%0d", k), {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
            case (k)
                0: begin req0_a = 26'd3; req0_b = 26'd4; end
                1: begin req1_a = 26'd7; req1_b = 26'd8; end
                2: req0_valid = 1'b0;
                default: req1_valid = 1'b0;
            endcase
            #1;
        end
        repeat (4) tick();
        check("t3_busy_drained", busy, 0);

        // 4: lone requester back-to-back, then pointer returns to 0
        exp1.push_back(52'd6); exp1.push_back(52'd20); exp1.push_back(52'd42);
        req1_a = 26'd2; req1_b = 26'd3; req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t4_lone_grant%0d", k), req1_ready, 1);
            @(posedge clk);
            #1;
            req1_a = req1_a + 26'd2;
            req1_b = req1_b + 26'd2;
            #1;
        end
        exp0.push_back(52'd1); exp1.push_back(52'd64);
        req0_a = 26'd1; req0_b = 26'd1; req0_valid = 1'b1;
        req1_a = 26'd8; req1_b = 26'd8;
        #1;
        check("t4_both_ready0", req0_ready, 1);
        check("t4_both_ready1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t4_then_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        repeat (4) tick();

        // 5: reset with two products in flight
        issue(0, 26'd9, 26'd9, 52'd81);
        issue(1, 26'd2, 26'd2, 52'd4);
        rstn = 1'b0;
        req0_a = 26'd9; req0_b = 26'd9; req0_valid = 1'b1;
        req1_a = 26'd2; req1_b = 26'd2; req1_valid = 1'b1;
        #1;
        check("t5_rst_ready0", req0_ready, 0);
        check("t5_rst_ready1", req1_ready, 0);
        check("t5_rst_rsp0", rsp0_valid, 0);
        check("t5_rst_rsp1", rsp1_valid, 0);
        check("t5_rst_busy", busy, 0);
        tick();
        rstn = 1'b1;
        #1;
        check("t5_post_busy", busy, 0);
        check("t5_post_ready0", req0_ready, 1);
        exp0.push_back(52'd81); exp1.push_back(52'd4);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t5_post_ready1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        repeat (4) tick();

        // 5b: reset while the pointer favours requester 1
        issue(0, 26'd1, 26'd1, 52'd1);
        rstn = 1'b0;
        req0_a = 26'd5; req0_b = 26'd5; req0_valid = 1'b1;
        req1_a = 26'd6; req1_b = 26'd6; req1_valid = 1'b1;
        tick();
        rstn = 1'b1;
        #1;
        check("t5b_prio_ready0", req0_ready, 1);
        check("t5b_prio_ready1", req1_ready, 0);
        exp0.push_back(52'd25); exp1.push_back(52'd36);
        tick();
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b0;
        repeat (4) tick();

        // 6: random traffic, scoreboarded by the response monitor
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [W-1:0] a, b;
                    repeat ($urandom_range(0, 3)) tick();
                    a = W'($urandom()); b = W'($urandom());
                    issue(0, a, b, {{W{1'b0}}, a} * {{W{1'b0}}, b});
                end
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    logic [W-1:0] a, b;
                    repeat ($urandom_range(0, 3)) tick();
                    a = W'($urandom()); b = W'($urandom());
                    issue(1, a, b, {{W{1'b0}}, a} * {{W{1'b0}}, b});
                end
            end
        join
        repeat (5) tick();
        check("t6_left0", exp0.size(), 0);
        check("t6_left1", exp1.size(), 0);
        check("t6_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/csa_mult_arbiter.md
Name: csa_mult_arbiter

Overview:
- Shares one pipelined 26x26 carry-save multiplier (multiplier_csa_26b) between two independent requesters.
- Each requester uses a valid/ready operand handshake. Grants are round-robin, at most one issue per cycle.
- Registers operands into the multiplier and tracks ownership of every in-flight product with a tag pipeline.
- Steers each product back to its requester as a one-cycle response pulse.
- Sits between the multiplier and the two datapath clients that previously each needed a dedicated multiplier.

Parameters:
- WIDTH, 26: operand width; product width is 2*WIDTH.
- LAT, 1: cycles from mul_a/mul_b change at the multiplier inputs to the corresponding mul_out value (1 for multiplier_csa_26b).

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rstn, input, 1: reset, synchronous, active-low.
- req0_valid, input, 1: requester 0 operands valid.
- req0_ready, output, 1: requester 0 operands accepted this cycle.
- req0_a, input, WIDTH: requester 0 multiplicand.
- req0_b, input, WIDTH: requester 0 multiplier.
- req1_valid, req1_ready, req1_a, req1_b: same as above, for requester 1.
- mul_a, output, WIDTH: registered operand a to the multiplier.
- mul_b, output, WIDTH: registered operand b to the multiplier.
- mul_out, input, 2*WIDTH: product from the multiplier.
- rsp0_valid, output, 1: product for requester 0 present this cycle.
- rsp0_data, output, 2*WIDTH: product for requester 0.
- rsp1_valid, rsp1_data: same as above, for requester 1.
- busy, output, 1: at least one operation in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is synchronous and active-low.
- Reset (rstn=0 at a rising edge):
  - priority pointer := requester 0; all tag stages invalid.
  - mul_a, mul_b := 0; rsp0/1_valid, rsp0/1_data := 0; busy := 0.
  - req0/1_ready are forced 0 combinationally while rstn=0.
- Handshake:
  - A transfer occurs on a rising edge where reqN_valid=1 and reqN_ready=1.
  - reqN_ready is a combinational function of both valids and the pointer; it never depends on reqN_ready itself.
  - The requester holds valid and operands stable until accepted. Dropping valid before acceptance is illegal (bench asserts this).
- Arbitration:
  - Both valid: grant the requester named by the pointer.
  - One valid: grant it regardless of the pointer.
  - Neither valid: no grant.
  - After any grant to N, the pointer := 1-N. The pointer is unchanged when there is no grant.
  - At most one ready high per cycle.
- Issue:
  - On a grant, mul_a/mul_b := granted operands at that edge.
  - With no grant, mul_a/mul_b := 0, so idle products are zero.
  - Tag stage 0 := {valid=grant, id=granted index}.
- Tag pipeline:
  - Depth LAT+1, shifts every cycle unconditionally; no stall exists.
  - When the final stage is valid, rspK_valid=1 and rspK_data=mul_out for K=id, combinationally from mul_out.
  - The other response has valid=0 and data=0.
- Latency: product appears on rspN exactly LAT+1 cycles after the accepting edge (2 cycles by default). Full throughput is one product per cycle, interleaved arbitrarily between requesters.
- Backpressure: none on responses. Requesters must sink rsp pulses on the cycle presented.
- Arithmetic: unsigned; full 2*WIDTH product. Width, sign and overflow come entirely from the multiplier.
- busy: OR of all tag-stage valids.
- Reset mid-operation: in-flight products are discarded, with no rsp_valid for them. The first grant after rstn rises goes to requester 0 if both are valid.
- Simultaneous events: a new grant and a response retiring in the same cycle are independent and both occur.

Test Plan:
1. Single op: after reset, req0 sends a=3, b=5 at edge T. Expect rsp0_valid=1, rsp0_data=15 at T+2 (LAT=1); rsp1_valid stays 0; busy high from T+1 to T+2.
2. Max operands: req1 sends a=b=0x3FFFFFF. Expect rsp1_data=0xFFFFFF8000001 two cycles later. Then a=0, b=0x3FFFFFF gives 0.
3. Contention: both valid for 4 accepts with operands (1,2), (3,4) on req0 and (5,6), (7,8) on req1. Expect grant order 0,1,0,1 and responses 2,30,12,56 on alternating rsp0/rsp1 on consecutive cycles.
4. Pointer with one active requester: req1 holds valid for 3 cycles. Expect all 3 granted back-to-back. Then both valid: the first grant goes to req0, since the pointer points to 0 after a req1 grant.
5. Reset mid-flight: issue req0 (9,9) and req1 (2,2) back-to-back, then pulse rstn=0 for one edge. Expect no rsp_valid for either, busy=0, and req ready low during reset.
6. Randomised 100 ops per requester with random valid gaps, checked against a scoreboard: every product returned exactly once, to the correct requester, in per-requester order.
